dma_uart_stream: RTL and testbench
==================================

# dma_uart_stream

Parametrised successor to the single-channel UART TX DMA. The block autonomously fetches a byte string from data memory through a word-wide read master and buffers it in an internal FIFO of configurable depth. It streams the string to `UART_TX` over the `data_av`/`ready` handshake. It supports a byte-count mode and a NUL-terminated mode, abort, a status register and an end-of-transfer interrupt. It sits beside the peripheral controller, configured through a 4-register slave port; its memory master is arbitrated by the interconnect fabric.

## Interface
- `DATA_WIDTH`, 32: memory word width; fixed at 32 (4 byte lanes).
- `ADDR_WIDTH`, 32: byte address width.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `LEN_WIDTH`, 16: width of length register/counter.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_ce`  in  1  register access strobe.
- `cfg_rw`  in  1  1 = write, 0 = read.
- `cfg_addr`  in  2  register select: 0 SRC, 1 LEN, 2 CTRL, 3 STATUS.
- `cfg_data_in`  in  32  write data.
- `cfg_data_out`  out  32  read data, combinational from `cfg_addr`; 0 when `cfg_ce`=0.
- `mem_req`  out  1  read request.
- `mem_addr`  out  ADDR_WIDTH  word-aligned read address (`[1:0]`=0).
- `mem_gnt`  in  1  grant; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  DATA_WIDTH  read word.
- `uart_data`  out  8  byte to transmit.
- `uart_data_av`  out  1  byte valid.
- `uart_ready`  in  1  UART idle/accepting.
- `irq`  out  1  level interrupt = `done & irq_en`.

## Operation
- Registers:
  - SRC: byte address.
  - LEN: byte count (count mode) or maximum length (NUL mode).
  - CTRL:
    - bit0 start (write-1, self-clearing).
    - bit1 mode: 0 count, 1 NUL.
    - bit2 irq_en.
    - bit3 abort (write-1).
  - STATUS (read):
    - bit0 busy.
    - bit1 done.
    - bit2 aborted.
    - bit3 limit_hit.
    - bits[15:8] FIFO level.
  - Any STATUS write clears done/aborted/limit_hit.
- SRC/LEN writes while busy are ignored; start while busy is ignored.
- Start clears done/aborted/limit_hit and latches SRC/LEN into working pointer/counter.
- Byte order little-endian: byte at address A is `mem_rdata[8*A[1:0]+7 : 8*A[1:0]]`. An unaligned SRC starts mid-word.
- FSM states:
  - IDLE: start with LEN=0 goes directly to DONE; otherwise goes to FETCH.
  - FETCH: `mem_req`=1 with stable `mem_addr` = ptr & ~3 until `mem_gnt`. Word is latched on grant; goes to UNPACK.
  - UNPACK:
    - Pushes one byte per cycle while FIFO not full. Increments ptr and decrements counter per byte.
    - In NUL mode a 0x00 byte is not pushed and ends the fetch phase → DRAIN.
    - Counter reaching 0 → DRAIN; in NUL mode this also sets limit_hit.
    - Lane 3 consumed with bytes remaining → FETCH.
  - DRAIN: wait until FIFO empty and `uart_ready`=1 → DONE.
  - DONE: done=1, busy=0 → IDLE (1 cycle).
- UART side:
  - `uart_data_av` = FIFO non-empty, registered; `uart_data` = FIFO head.
  - Pop on rising edge with `uart_data_av & uart_ready`.
  - `uart_data_av` is forced low in the cycle after each pop, to cover UART ready latency.
- Abort, in any non-IDLE state:
  - `mem_req` drops next cycle and the FIFO is flushed.
  - aborted=1, done=1, state → IDLE.
  - A byte already accepted by the UART completes.
- Simultaneous start and abort: abort wins, no transfer.

## Timing
- Reset values:
  - All outputs 0.
  - All registers 0.
  - FSM IDLE, FIFO empty.
- Start written at edge N → busy=1 and `mem_req`=1 after edge N.
- Grant at edge G → first FIFO push at G+1 → `uart_data_av`=1 after G+2.
- Word-to-FIFO throughput: 1 byte/cycle; next FETCH begins in the cycle after the last lane push.
- Full FIFO stalls UNPACK with no byte lost or duplicated; an empty FIFO deasserts `uart_data_av`.
- `irq` rises the cycle after DONE and falls the cycle after STATUS write or start.
- Counter and pointer arithmetic are modulo width; pointer wrap at 2^ADDR_WIDTH is permitted.

## Test plan
- Count mode: SRC=0x100, LEN=5, memory words 0x44434241 at 0x100 and 0x00000045 at 0x104, `uart_ready` tied 1 → UART receives 0x41..0x45 in order; exactly 2 grants; done=1, `irq`=1 with irq_en.
- NUL mode, unaligned: SRC=0x102, LEN=16, bytes "hi\0" from 0x102 → UART receives 0x68, 0x69 only; limit_hit=0. Same test with LEN=1 → receives 0x68 only; limit_hit=1.
- Backpressure: LEN=20, FIFO_DEPTH=4, `uart_ready` low for 200 cycles → FIFO level holds at 4 and `mem_req` stays low after the stall. Release → all 20 bytes arrive in order, no duplicates.
- Grant delay: hold `mem_gnt`=0 for 10 cycles → `mem_req`/`mem_addr` stable throughout; data correct after grant.
- Abort mid-transfer after 3 bytes sent → `mem_req` low next cycle, FIFO level 0; aborted=1, done=1, busy=0; no further `uart_data_av`.
- Edge cases:
  - LEN=0 start → done next cycle, no `mem_req`.
  - Start while busy ignored.
  - Async `rst` mid-FETCH → all outputs 0 immediately.

Source files
------------

// File: rtl/dma_uart_stream_if.sv
// rtl/dma_uart_stream_if.sv - Register, memory-read and UART-stream bundle of the TX stream DMA
interface dma_uart_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Register slave port
  logic                  cfg_ce;
  logic                  cfg_rw;
  logic [1:0]            cfg_addr;
  logic [31:0]           cfg_data_in;
  logic [31:0]           cfg_data_out;
  // Word-wide memory read master
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // UART transmit handshake
  logic [7:0]            uart_data;
  logic                  uart_data_av;
  logic                  uart_ready;
  // Interrupt
  logic                  irq;

  // DMA side: drives memory requests, the UART byte stream, read data and irq
  modport master (
    input  cfg_ce, cfg_rw, cfg_addr, cfg_data_in, mem_gnt, mem_rdata, uart_ready,
    output cfg_data_out, mem_req, mem_addr, uart_data, uart_data_av, irq
  );

  // System side: controller, memory fabric and UART
  modport slave (
    output cfg_ce, cfg_rw, cfg_addr, cfg_data_in, mem_gnt, mem_rdata, uart_ready,
    input  cfg_data_out, mem_req, mem_addr, uart_data, uart_data_av, irq
  );
endinterface

// File: rtl/dma_uart_stream.sv
// rtl/dma_uart_stream.sv - Memory-to-UART byte stream DMA with count/NUL modes and byte FIFO
module dma_uart_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dma_uart_stream_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UNPACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  limit_q, limit_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [7:0]            fifo_q [FIFO_DEPTH];
  logic [7:0]            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q, wr_d;
  logic [PTR_W-1:0]      rd_q, rd_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  av_q, av_d;

  logic       cfg_wr;
  logic       busy;
  logic       fifo_full;
  logic       start_req;
  logic       abort_req;
  logic       push;
  logic       pop;
  logic       flush;
  logic [7:0] cur_byte;

  assign cfg_wr    = bus.cfg_ce & bus.cfg_rw;
  assign busy      = (state_q == S_FETCH) || (state_q == S_UNPACK) || (state_q == S_DRAIN);
  assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
  // Little-endian lane select: the low pointer bits pick the byte within the latched word
  assign cur_byte  = word_q[{ptr_q[1:0], 3'b000} +: 8];
  assign pop       = av_q & bus.uart_ready;

  assign bus.mem_req      = (state_q == S_FETCH);
  assign bus.mem_addr     = (state_q == S_FETCH) ? {ptr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.uart_data    = fifo_q[rd_q];
  assign bus.uart_data_av = av_q;
  assign bus.irq          = done_q & irq_en_q;

  // Register writes, transfer FSM next-state, and abort override
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    len_d     = len_q;
    mode_d    = mode_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    limit_d   = limit_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    start_req = 1'b0;
    abort_req = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;

    if (cfg_wr) begin
      case (bus.cfg_addr)
        2'd0: if (!busy) src_d = ADDR_WIDTH'(bus.cfg_data_in);
        2'd1: if (!busy) len_d = LEN_WIDTH'(bus.cfg_data_in);
        2'd2: begin
          irq_en_d  = bus.cfg_data_in[2];
          if (!busy) mode_d = bus.cfg_data_in[1];
          start_req = bus.cfg_data_in[0];
          abort_req = bus.cfg_data_in[3];
        end
        default: begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          limit_d   = 1'b0;
        end
      endcase
    end

    case (state_q)
      // DONE behaves like IDLE for a new start so a start issued in that cycle is not lost
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_req && !abort_req) begin
          done_d    = 1'b0;
          aborted_d = 1'b0;
          limit_d   = 1'b0;
          ptr_d     = src_q;
          cnt_d     = len_q;
          if (len_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (bus.mem_gnt) begin
          word_d  = bus.mem_rdata;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        // A terminator needs no FIFO slot, so it is honoured even when the FIFO is full
        if (mode_q && (cur_byte == 8'h00)) begin
          state_d = S_DRAIN;
        end else if (!fifo_full) begin
          push  = 1'b1;
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
            if (mode_q) limit_d = 1'b1;
          end else if (ptr_q[1:0] == 2'b11) begin
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if ((level_q == '0) && bus.uart_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && busy) begin
      state_d   = S_IDLE;
      push      = 1'b0;
      flush     = 1'b1;
      aborted_d = 1'b1;
      done_d    = 1'b1;
    end
  end

  // Byte FIFO bookkeeping and the registered byte-valid with its post-pop gap
  always_comb begin
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (push) begin
        fifo_d[wr_q] = cur_byte;
        wr_d         = wr_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
    av_d = (level_q != '0) && !pop && !flush;
  end

  // Register read mux; reads return zero when the port is not selected
  always_comb begin
    bus.cfg_data_out = '0;
    if (bus.cfg_ce) begin
      case (bus.cfg_addr)
        2'd0:    bus.cfg_data_out = 32'(src_q);
        2'd1:    bus.cfg_data_out = 32'(len_q);
        2'd2:    bus.cfg_data_out = {29'd0, irq_en_q, mode_q, 1'b0};
        default: bus.cfg_data_out = {16'd0, 8'(level_q), 4'd0, limit_q, aborted_q, done_q, busy};
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      limit_q   <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      av_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      limit_q   <= limit_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      av_q      <= av_d;
      fifo_q    <= fifo_d;
    end
  end
endmodule

// File: tb/tb_dma_uart_stream.sv
// tb/tb_dma_uart_stream.sv - Directed self-checking bench for dma_uart_stream
module tb_dma_uart_stream;
  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        gnt_en = 1'b0;
  logic [31:0] mem_arr [256];
  logic [7:0]  rx [$];
  int          n_gnt  = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  dma_uart_stream_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dma_uart_stream #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(4),
    .LEN_WIDTH (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: zero-wait grant when enabled, data valid with the grant
  assign bus.mem_gnt   = bus.mem_req & gnt_en;
  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];

  // UART receiver and grant counter
  always @(posedge clk) begin
    if (bus.uart_data_av && bus.uart_ready) rx.push_back(bus.uart_data);
    if (bus.mem_req && bus.mem_gnt) n_gnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_ce      = 1'b1;
    bus.cfg_rw      = 1'b1;
    bus.cfg_addr    = a;
    bus.cfg_data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_ce      = 1'b0;
    bus.cfg_rw      = 1'b0;
    bus.cfg_data_in = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_ce   = 1'b1;
    bus.cfg_rw   = 1'b0;
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_data_out;
    bus.cfg_ce = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    logic [31:0] s;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      cfg_read(2'd3, s);
      if (s[1]) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_rx(input string tag, input int base, input logic [7:0] first, input int n);
    logic [31:0] got;
    check_eq({tag, "_count"}, 32'(rx.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (base + i < rx.size()) ? 32'(rx[base + i]) : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_byte%0d", tag, i), got, 32'(first + 8'(i)));
    end
  endtask

  initial begin
    logic [31:0] r;
    int base;
    int g0;
    int bad;
    int guard;

    bus.cfg_ce      = 1'b0;
    bus.cfg_rw      = 1'b0;
    bus.cfg_addr    = 2'd0;
    bus.cfg_data_in = '0;
    bus.uart_ready  = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[64] = 32'h4443_4241;
    mem_arr[65] = 32'h0000_0045;
    for (int k = 0; k < 5; k++)
      mem_arr[128 + k] = {8'(19 + 4 * k), 8'(18 + 4 * k), 8'(17 + 4 * k), 8'(16 + 4 * k)};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_uart_av", 32'(bus.uart_data_av), 32'd0);
    check_eq("rst_irq", 32'(bus.irq), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    cfg_read(2'd3, r); check_eq("rst_status", r, 32'd0);
    cfg_read(2'd0, r); check_eq("rst_src", r, 32'd0);
    cfg_read(2'd1, r); check_eq("rst_len", r, 32'd0);
    @(negedge clk);

    // Count mode with a held-off grant and exact first-byte latency
    bus.uart_ready = 1'b1;
    base = rx.size();
    g0   = n_gnt;
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'd5);
    cfg_write(2'd2, 32'h5);
    check_eq("t1_req_after_start", 32'(bus.mem_req), 32'd1);
    cfg_read(2'd3, r); check_eq("t1_status_busy", r, 32'h1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h100)) bad++;
    end
    check_eq("t1_req_addr_stable", 32'(bad), 32'd0);
    gnt_en = 1'b1;
    @(negedge clk); check_eq("t1_av_g0", 32'(bus.uart_data_av), 32'd0);
    @(negedge clk); check_eq("t1_av_g1", 32'(bus.uart_data_av), 32'd0);
    @(negedge clk); check_eq("t1_av_g2", 32'(bus.uart_data_av), 32'd1);
    check_eq("t1_data_g2", 32'(bus.uart_data), 32'h41);
    @(negedge clk); check_eq("t1_av_gap", 32'(bus.uart_data_av), 32'd0);
    @(negedge clk); check_eq("t1_av_g4", 32'(bus.uart_data_av), 32'd1);
    check_eq("t1_data_g4", 32'(bus.uart_data), 32'h42);
    wait_done("t1", 200);
    check_rx("t1", base, 8'h41, 5);
    check_eq("t1_grants", 32'(n_gnt - g0), 32'd2);
    cfg_read(2'd3, r); check_eq("t1_status_done", r, 32'h2);
    check_eq("t1_irq_high", 32'(bus.irq), 32'd1);
    @(negedge clk);
    cfg_write(2'd3, 32'd0);
    check_eq("t1_irq_cleared", 32'(bus.irq), 32'd0);
    cfg_read(2'd3, r); check_eq("t1_status_cleared", r, 32'd0);
    @(negedge clk);

    // NUL mode from an unaligned source, terminator then length limit
    mem_arr[64] = 32'h6968_5A5A;
    mem_arr[65] = 32'h5A5A_5A00;
    base = rx.size();
    g0   = n_gnt;
    cfg_write(2'd0, 32'h102);
    cfg_write(2'd1, 32'd16);
    cfg_write(2'd2, 32'h3);
    wait_done("t2", 200);
    check_rx("t2", base, 8'h68, 2);
    check_eq("t2_grants", 32'(n_gnt - g0), 32'd2);
    cfg_read(2'd3, r); check_eq("t2_status_nolimit", r, 32'h2);
    check_eq("t2_irq_disabled", 32'(bus.irq), 32'd0);
    @(negedge clk);
    base = rx.size();
    g0   = n_gnt;
    cfg_write(2'd1, 32'd1);
    cfg_write(2'd2, 32'h3);
    wait_done("t2b", 200);
    check_rx("t2b", base, 8'h68, 1);
    check_eq("t2b_grants", 32'(n_gnt - g0), 32'd1);
    cfg_read(2'd3, r); check_eq("t2b_status_limit", r, 32'hA);
    @(negedge clk);

    // Backpressure: UART stalled, FIFO fills to depth and fetching stops
    bus.uart_ready = 1'b0;
    base = rx.size();
    g0   = n_gnt;
    cfg_write(2'd0, 32'h200);
    cfg_write(2'd1, 32'd20);
    cfg_write(2'd2, 32'h1);
    repeat (200) @(negedge clk);
    cfg_read(2'd3, r); check_eq("t3_status_full", r, 32'h0401);
    check_eq("t3_req_low", 32'(bus.mem_req), 32'd0);
    check_eq("t3_grants_stalled", 32'(n_gnt - g0), 32'd2);
    check_eq("t3_av_held", 32'(bus.uart_data_av), 32'd1);
    check_eq("t3_head", 32'(bus.uart_data), 32'h10);
    check_eq("t3_rx_none", 32'(rx.size() - base), 32'd0);
    @(negedge clk);
    bus.uart_ready = 1'b1;
    wait_done("t3", 400);
    check_rx("t3", base, 8'h10, 20);
    cfg_read(2'd3, r); check_eq("t3_status_done", r, 32'h2);
    @(negedge clk);

    // Abort after three bytes reached the UART
    base = rx.size();
    cfg_write(2'd2, 32'h1);
    guard = 0;
    while ((rx.size() - base) < 3 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("t4_pre_abort_bytes", 32'(rx.size() - base), 32'd3);
    cfg_write(2'd2, 32'h8);
    check_eq("t4_req_low", 32'(bus.mem_req), 32'd0);
    check_eq("t4_av_low", 32'(bus.uart_data_av), 32'd0);
    cfg_read(2'd3, r); check_eq("t4_status_aborted", r, 32'h6);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.uart_data_av !== 1'b0) bad++;
    end
    check_eq("t4_no_av_after", 32'(bad), 32'd0);
    check_rx("t4", base, 8'h10, 3);

    // Zero length completes at once without touching memory
    cfg_write(2'd3, 32'd0);
    cfg_write(2'd1, 32'd0);
    g0 = n_gnt;
    cfg_write(2'd2, 32'h1);
    cfg_read(2'd3, r); check_eq("t5_status_done", r, 32'h2);
    check_eq("t5_req_low", 32'(bus.mem_req), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("t5_no_grants", 32'(n_gnt - g0), 32'd0);

    // Writes and restart while busy are ignored
    mem_arr[64] = 32'h4443_4241;
    mem_arr[65] = 32'h0000_0045;
    gnt_en = 1'b0;
    base   = rx.size();
    cfg_write(2'd0, 32'h100);
    cfg_write(2'd1, 32'd5);
    cfg_write(2'd2, 32'h1);
    cfg_write(2'd0, 32'h300);
    cfg_write(2'd1, 32'd2);
    cfg_write(2'd2, 32'h1);
    cfg_read(2'd0, r); check_eq("t6_src_kept", r, 32'h100);
    cfg_read(2'd1, r); check_eq("t6_len_kept", r, 32'd5);
    check_eq("t6_addr_kept", bus.mem_addr, 32'h100);
    @(negedge clk);
    gnt_en = 1'b1;
    wait_done("t6", 200);
    check_rx("t6", base, 8'h41, 5);
    @(negedge clk);

    // Start together with abort: no transfer
    cfg_write(2'd3, 32'd0);
    g0 = n_gnt;
    cfg_write(2'd2, 32'h9);
    cfg_read(2'd3, r); check_eq("t7_status_idle", r, 32'd0);
    check_eq("t7_req_low", 32'(bus.mem_req), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("t7_no_grants", 32'(n_gnt - g0), 32'd0);

    // Asynchronous reset while fetching
    gnt_en = 1'b0;
    cfg_write(2'd2, 32'h5);
    check_eq("t8_req_before_rst", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t8_req_async", 32'(bus.mem_req), 32'd0);
    check_eq("t8_addr_async", bus.mem_addr, 32'd0);
    check_eq("t8_av_async", 32'(bus.uart_data_av), 32'd0);
    check_eq("t8_irq_async", 32'(bus.irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cfg_read(2'd0, r); check_eq("t8_src_reset", r, 32'd0);
    cfg_read(2'd2, r); check_eq("t8_ctrl_reset", r, 32'd0);
    cfg_read(2'd3, r); check_eq("t8_status_reset", r, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
